csr_counter_bank: RTL and testbench
===================================

// Module: csr_counter_bank
// PURPOSE
//  Register-bus reader/writer side of the hardware counters: holds mcycle/minstret as full 64-bit
//  counters plus mcountinhibit, and services CSR reads and writes from the core's CSR unit.
//  Sits between the CSR decode stage and the retire/halt event sources; one access per two cycles.
// PARAMETERS
//  ADDR_W   12   CSR address width
//  CNT_W    64   counter width; legal 33..64; bits above CNT_W-1 in the high half read as 0
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  reg_en         in   1       access request, held until accepted
//  reg_ready      out  1       request accepted when reg_en && reg_ready
//  reg_wr         in   1       1 = write, 0 = read
//  reg_addr       in   ADDR_W  CSR address
//  reg_wdata      in   32      write data
//  reg_rvalid     out  1       response pulse, one cycle after acceptance
//  reg_rdata      out  32      read data, valid with reg_rvalid
//  reg_err        out  1       access error, valid with reg_rvalid
//  instret_trig   in   1       one-cycle pulse per retired instruction
//  counterstop    in   1       global halt (debug): freezes both counters while high
// BEHAVIOUR
//  - Reset: counters=0, mcountinhibit=0, reg_ready=1, reg_rvalid=0, reg_rdata=0, reg_err=0, FSM=IDLE.
//  - FSM: IDLE (reg_ready=1) --accept--> RESP (reg_ready=0, reg_rvalid=1) --> IDLE. No back-to-back.
//  - Address map: 0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi (RW); 0x320 mcountinhibit
//    (RW, bit0=CY, bit2=IR, other bits RAZ/WI); 0xC00/0xC80/0xC02/0xC82 user aliases (RO).
//  - Increment: mcycle +1 every cycle when !counterstop && !inhibit[0]; minstret +1 when
//    instret_trig && !counterstop && !inhibit[2]. Wrap 2^CNT_W-1 -> 0 silently.
//  - Read samples value at accept cycle (pre-increment); returned in RESP cycle.
//  - Write to lo: counter[31:0]<=wdata, [63:32] unchanged, no increment that cycle (write wins,
//    pending carry discarded). Write to hi: [CNT_W-1:32]<=wdata, lo unchanged, no increment that cycle.
//  - mcountinhibit write takes effect from next cycle; increment in write cycle uses old value.
//  - Write to RO alias or any unmapped address: no state change, reg_err=1, reg_rdata=0.
//    Read of unmapped address: reg_err=1, reg_rdata=0. Legal accesses: reg_err=0; write rdata=0.
//  - reg_en dropped while in RESP is ignored; reg_addr/wdata only sampled at accept.
//  - rst mid-access: FSM to IDLE, pending response discarded, all registers to reset values.
// CONFIGURATION
//  CSR_CNT_SNAPSHOT_EN defined: read of any lo address (0xB00/0xB02/0xC00/0xC02) also latches
//   that counter's high half into a per-counter snapshot; following read of matching hi address
//   returns the snapshot (atomic 64-bit read); write to hi or lo clears snapshot-valid.
//   Snapshot-valid cleared after its hi read; hi read with snapshot invalid returns live value.
//  Not defined: hi reads always return live value; no snapshot registers.
// STRUCTURE
//  Package csr_cnt_pkg: CSR address localparams, mcountinhibit bit indices, FSM state enum.
//  Sub-module cnt_dff64: one counter with inc, wr_lo, wr_hi, wdata, value; instanced twice.
// TESTING
//  1 Reset, counterstop=0, inhibit=0; read 0xB00 after N cycles -> rdata = cycles since reset at accept.
//  2 Write 0xB00=0xFFFF_FFFF, 0xB80=0; idle 2 cycles; read 0xB80 -> 0x1 (carry into hi).
//  3 Write 0x320=0x4; pulse instret_trig x5; read 0xB02 -> unchanged; write 0x320=0; 3 pulses -> +3.
//  4 counterstop=1 for 10 cycles with trig pulses -> mcycle/minstret frozen; release -> resume.
//  5 Write 0xC00 -> reg_err=1, mcycle unaffected; read 0x7FF -> reg_err=1, rdata=0.
//  6 SNAPSHOT_EN: mcycle lo=0xFFFF_FFF0; read 0xB00, wait 30 cycles, read 0xB80 -> pre-carry hi.

Source files
------------

// File: rtl/csr_cnt_pkg.sv
// Shared CSR addresses, mcountinhibit bit positions and access FSM states
// for the mcycle/minstret counter bank.
package csr_cnt_pkg;

  localparam logic [11:0] A_MCYCLE        = 12'hB00;
  localparam logic [11:0] A_MCYCLEH       = 12'hB80;
  localparam logic [11:0] A_MINSTRET      = 12'hB02;
  localparam logic [11:0] A_MINSTRETH     = 12'hB82;
  localparam logic [11:0] A_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] A_CYCLE         = 12'hC00;
  localparam logic [11:0] A_CYCLEH        = 12'hC80;
  localparam logic [11:0] A_INSTRET       = 12'hC02;
  localparam logic [11:0] A_INSTRETH      = 12'hC82;

  localparam int INH_CY = 0;
  localparam int INH_IR = 2;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  function automatic logic [31:0] hi32(input logic [63:0] v);
    return v[63:32];
  endfunction

endpackage

// File: rtl/cnt_dff64.sv
// One architectural counter: half-word writes take priority over the increment,
// so a write cycle never also counts.
module cnt_dff64 #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst)        value              <= '0;
    else if (wr_lo) value[31:0]        <= wdata;
    else if (wr_hi) value[CNT_W-1:32]  <= wdata[CNT_W-33:0];
    else if (inc)   value              <= value + CNT_W'(1);
  end

endmodule

// File: rtl/csr_counter_bank.sv
// mcycle/minstret/mcountinhibit CSR bank, one access per two cycles.
// Optional CSR_CNT_SNAPSHOT_EN: a lo read latches the hi half so the next hi read is atomic.
module csr_counter_bank
  import csr_cnt_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_en,
  output logic              reg_ready,
  input  logic              reg_wr,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic              reg_rvalid,
  output logic [31:0]       reg_rdata,
  output logic              reg_err,
  input  logic              instret_trig,
  input  logic              counterstop
);

  state_t state;
  logic   inh_cy, inh_ir;
  logic   acc, mapped, ro, sel_inh, wr_ok;
  logic   [1:0] sel_lo, sel_hi, sel_ulo, sel_uhi, wr_lo, wr_hi, inc;
  logic   [1:0][CNT_W-1:0] cnt_val;
  logic   [1:0][31:0] hi_rd;
  logic   [31:0] rd_data;
  logic   rd_err;

  assign acc     = reg_en && reg_ready;
  // index 0 = cycle counter, index 1 = instret counter
  assign sel_lo  = {reg_addr == ADDR_W'(A_MINSTRET),  reg_addr == ADDR_W'(A_MCYCLE)};
  assign sel_hi  = {reg_addr == ADDR_W'(A_MINSTRETH), reg_addr == ADDR_W'(A_MCYCLEH)};
  assign sel_ulo = {reg_addr == ADDR_W'(A_INSTRET),   reg_addr == ADDR_W'(A_CYCLE)};
  assign sel_uhi = {reg_addr == ADDR_W'(A_INSTRETH),  reg_addr == ADDR_W'(A_CYCLEH)};
  assign sel_inh = reg_addr == ADDR_W'(A_MCOUNTINHIBIT);
  assign ro      = |sel_ulo || |sel_uhi;
  assign mapped  = ro || |sel_lo || |sel_hi || sel_inh;
  assign wr_ok   = acc && reg_wr && mapped && !ro;
  assign wr_lo   = {2{wr_ok}} & sel_lo;
  assign wr_hi   = {2{wr_ok}} & sel_hi;
  assign inc[0]  = !counterstop && !inh_cy;
  assign inc[1]  = instret_trig && !counterstop && !inh_ir;

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    logic [31:0] hi_live;

    cnt_dff64 #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[g]),
      .wr_lo (wr_lo[g]),
      .wr_hi (wr_hi[g]),
      .wdata (reg_wdata),
      .value (cnt_val[g])
    );

    assign hi_live = hi32(64'(cnt_val[g]));

`ifdef CSR_CNT_SNAPSHOT_EN
    logic [31:0] snap;
    logic        snap_vld;

    always_ff @(posedge clk) begin
      if (rst) begin
        snap     <= '0;
        snap_vld <= 1'b0;
      end else if (wr_lo[g] || wr_hi[g]) begin
        snap_vld <= 1'b0;
      end else if (acc && !reg_wr && (sel_lo[g] || sel_ulo[g])) begin
        snap     <= hi_live;
        snap_vld <= 1'b1;
      end else if (acc && !reg_wr && (sel_hi[g] || sel_uhi[g])) begin
        snap_vld <= 1'b0;
      end
    end

    assign hi_rd[g] = snap_vld ? snap : hi_live;
`else
    assign hi_rd[g] = hi_live;
`endif
  end

  // Read data is sampled pre-increment at the accept edge; writes and errors return zero.
  always_comb begin
    rd_data = '0;
    rd_err  = !mapped || (reg_wr && ro);
    if (!reg_wr) begin
      for (int i = 0; i < 2; i++) begin
        if (sel_lo[i] || sel_ulo[i]) rd_data = cnt_val[i][31:0];
        if (sel_hi[i] || sel_uhi[i]) rd_data = hi_rd[i];
      end
      if (sel_inh) rd_data = {29'b0, inh_ir, 1'b0, inh_cy};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      reg_ready  <= 1'b1;
      reg_rvalid <= 1'b0;
      reg_rdata  <= '0;
      reg_err    <= 1'b0;
      inh_cy     <= 1'b0;
      inh_ir     <= 1'b0;
    end else begin
      if (wr_ok && sel_inh) begin
        inh_cy <= reg_wdata[INH_CY];
        inh_ir <= reg_wdata[INH_IR];
      end
      case (state)
        S_IDLE: begin
          if (acc) begin
            state      <= S_RESP;
            reg_ready  <= 1'b0;
            reg_rvalid <= 1'b1;
            reg_rdata  <= rd_data;
            reg_err    <= rd_err;
          end
        end
        default: begin
          state      <= S_IDLE;
          reg_ready  <= 1'b1;
          reg_rvalid <= 1'b0;
          reg_rdata  <= '0;
          reg_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed bench for csr_counter_bank: expected responses queued at issue,
// compared by a monitor whenever reg_rvalid is seen.
module tb_csr_counter_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_en, reg_ready, reg_wr, reg_rvalid, reg_err;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        instret_trig, counterstop;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  csr_counter_bank #(.ADDR_W(12), .CNT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_en       (reg_en),
    .reg_ready    (reg_ready),
    .reg_wr       (reg_wr),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rvalid   (reg_rvalid),
    .reg_rdata    (reg_rdata),
    .reg_err      (reg_err),
    .instret_trig (instret_trig),
    .counterstop  (counterstop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reg_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid: got rdata=0x%08h err=%0b expected no response",
                   reg_rdata, reg_err);
        end else begin
          e = sb.pop_front();
          if (reg_rdata !== e.rdata || reg_err !== e.err) begin
            errors++;
            $display("FAIL %s: got rdata=0x%08h err=%0b expected rdata=0x%08h err=%0b",
                     e.name, reg_rdata, reg_err, e.rdata, e.err);
          end
        end
      end
    end
  endtask

  // Called at #1 after an edge; accept on the next edge, returns #1 after the response edge.
  task automatic acc(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input bit exp_err, input string name,
                     input bit trig = 1'b0);
    int n = 0;
    reg_en = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = wdata; instret_trig = trig;
    while (!reg_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!reg_ready) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got reg_ready=0 expected 1 within 8 cycles", name);
      reg_en = 1'b0; instret_trig = 1'b0;
      return;
    end
    sb.push_back('{exp_rdata, exp_err, name});
    @(posedge clk); #1;
    reg_en = 1'b0; instret_trig = 1'b0;
    chk({name, "_ready_low"}, {31'b0, reg_ready}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      instret_trig = 1'b1;
      @(posedge clk); #1;
      instret_trig = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reg_en = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
    instret_trig = 1'b0; counterstop = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  {31'b0, reg_ready},  32'd1);
    chk("rst_rvalid", {31'b0, reg_rvalid}, 32'd0);
    chk("rst_rdata",  reg_rdata,           32'd0);
    chk("rst_err",    {31'b0, reg_err},    32'd0);
    rst = 1'b0;

    // mcycle counts every edge after reset release; read samples pre-increment value
    repeat (10) @(posedge clk);
    #1;
    acc(0, 12'hB00, 0, 32'd10, 0, "mcycle_after_10");
    acc(0, 12'hB80, 0, 32'd0,  0, "mcycleh_zero");
    acc(0, 12'hC00, 0, 32'd14, 0, "cycle_alias");
    acc(0, 12'hC80, 0, 32'd0,  0, "cycleh_alias");

    // carry from lo into hi
    acc(1, 12'hB80, 32'h0,         32'd0, 0, "wr_mcycleh");
    acc(1, 12'hB00, 32'hFFFF_FFFF, 32'd0, 0, "wr_mcycle");
    repeat (2) @(posedge clk);
    #1;
    acc(0, 12'hB80, 0, 32'd1, 0, "carry_hi");
    acc(0, 12'hB00, 0, 32'd4, 0, "carry_lo");

    // mcountinhibit: write-cycle increment uses the old inhibit value
    acc(1, 12'h320, 32'h4, 32'd0, 0, "wr_inh_ir", 1'b1);
    pulses(5);
    acc(0, 12'h320, 0, 32'h4, 0, "rd_inh");
    acc(0, 12'hB02, 0, 32'd1, 0, "minstret_inhibited");
    acc(1, 12'h320, 32'h0, 32'd0, 0, "wr_inh_clr", 1'b1);
    pulses(3);
    acc(0, 12'hB02, 0, 32'd4, 0, "minstret_resumed");
    acc(0, 12'hC02, 0, 32'd4, 0, "instret_alias");
    acc(0, 12'hC82, 0, 32'd0, 0, "instreth_alias");
    acc(0, 12'hB82, 0, 32'd0, 0, "minstreth");
    acc(1, 12'h320, 32'hFFFF_FFFF, 32'd0, 0, "wr_inh_all");
    pulses(2);
    acc(0, 12'h320, 0, 32'h5, 0, "rd_inh_raz");
    acc(0, 12'hB02, 0, 32'd4, 0, "minstret_inh_all");
    acc(1, 12'h320, 32'h0, 32'd0, 0, "wr_inh_zero");

    // counterstop freezes both counters
    acc(1, 12'hB80, 32'h0,   32'd0, 0, "wr_mcycleh_2");
    acc(1, 12'hB00, 32'h100, 32'd0, 0, "wr_mcycle_100");
    counterstop = 1'b1;
    instret_trig = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    instret_trig = 1'b0;
    acc(0, 12'hB00, 0, 32'h101, 0, "mcycle_frozen");
    acc(0, 12'hB02, 0, 32'd4,   0, "minstret_frozen");
    counterstop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    acc(0, 12'hB00, 0, 32'h104, 0, "mcycle_resumed");

    // errors: RO alias write, unmapped accesses
    acc(1, 12'hC00, 32'hDEAD_BEEF, 32'd0, 1, "wr_ro_alias");
    acc(0, 12'hB00, 0, 32'h108, 0, "mcycle_after_ro_wr");
    pulses(2);
    acc(0, 12'hB02, 0, 32'd6, 0, "minstret_plus2");
    acc(0, 12'h7FF, 0, 32'd0, 1, "rd_unmapped");
    acc(1, 12'h123, 32'h1, 32'd0, 1, "wr_unmapped");
    acc(1, 12'hC80, 32'h1, 32'd0, 1, "wr_ro_hi_alias");

    // lo read then delayed hi read across a carry
    acc(1, 12'hB80, 32'h0,         32'd0, 0, "wr_mcycleh_3");
    acc(1, 12'hB00, 32'hFFFF_FFF0, 32'd0, 0, "wr_mcycle_fff0");
    acc(0, 12'hB00, 0, 32'hFFFF_FFF1, 0, "snap_lo");
    repeat (30) @(posedge clk);
    #1;
`ifdef CSR_CNT_SNAPSHOT_EN
    acc(0, 12'hB80, 0, 32'd0, 0, "snap_hi");
`else
    acc(0, 12'hB80, 0, 32'd1, 0, "live_hi");
`endif
    acc(0, 12'hB80, 0, 32'd1, 0, "hi_live_again");

    // reset coinciding with a request: no response, everything back to reset values
    rst = 1'b1; reg_en = 1'b1; reg_wr = 1'b0; reg_addr = 12'hB00;
    @(posedge clk); #1;
    rst = 1'b0; reg_en = 1'b0;
    chk("midrst_ready",  {31'b0, reg_ready},  32'd1);
    chk("midrst_rvalid", {31'b0, reg_rvalid}, 32'd0);
    acc(0, 12'hB00, 0, 32'd0, 0, "mcycle_after_rst");
    acc(0, 12'hB80, 0, 32'd0, 0, "mcycleh_after_rst");
    acc(0, 12'hB02, 0, 32'd0, 0, "minstret_after_rst");
    acc(0, 12'h320, 0, 32'd0, 0, "inh_after_rst");

    @(posedge clk); #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
